addsub_seq: RTL
===============

Name: addsub_seq

Overview:
- Byte-serial multi-word adder/subtractor sequencer.
- Accepts one NBYTES-wide operand pair per transaction over a valid/ready handshake.
- Drives an internal 8-bit add/sub slice once per cycle from LSB to MSB, chaining carry/borrow between bytes.
- Returns the full-width result, carry and signed overflow on a valid/ready output.
- Lets wide arithmetic (32/64-bit) reuse one byte-wide datapath instead of a full-width adder.

Parameters:
- NBYTES, 4, number of 8-bit slices per operand; legal range 2..16.
- IDXW, $clog2(NBYTES+1), width of the internal byte index counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair and op_sub are valid.
- in_ready  output  1  block can accept a transaction.
- op_sub  input  1  0 = A+B, 1 = A-B.
- op_a  input  8*NBYTES  operand A, unsigned or two's complement.
- op_b  input  8*NBYTES  operand B.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts the result.
- result  output  8*NBYTES  A+B or A-B, modulo 2^(8*NBYTES).
- carry_out  output  1  final carry; for subtract, 1 = no borrow (A>=B unsigned).
- overflow  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, byte index=0, in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, busy=0. Operand registers are cleared to 0.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- IDLE: on an edge with in_valid&in_ready:
  - latch op_a and op_sub;
  - latch op_b XOR {8*NBYTES{op_sub}};
  - set carry register = op_sub; set idx=0; go to RUN.
- RUN, each edge:
  - compute s = A[idx] + Beff[idx] + c (9-bit);
  - write s[7:0] into result byte idx;
  - set c = s[8]; idx = idx+1.
- RUN, after processing byte NBYTES-1:
  - carry_out = s[8];
  - overflow = (A_msb == Beff_msb) && (s[7] != A_msb);
  - go to DONE.
- Latency: exactly NBYTES edges from the accept edge to the edge on which out_valid rises.
- DONE:
  - result, carry_out and overflow hold stable while out_valid && !out_ready.
  - On an edge with out_ready=1, go to IDLE; outputs keep their last values.
  - No accept on the same edge as the output handshake, so throughput is one transaction per NBYTES+2 cycles.
- in_valid during RUN or DONE is ignored; the producer must hold it until in_ready.
- Changing op_a, op_b or op_sub after the accept edge has no effect on the transaction in flight.
- Reset asserted mid-RUN or in DONE aborts the transaction immediately: all state returns to reset values and no out_valid is produced.
- Width rules: intermediate sum is 9 bits; result wraps modulo 2^(8*NBYTES); there is no internal saturation unless the optional feature is enabled.
- idx never exceeds NBYTES-1 in RUN; it resets to 0 on accept.

Optional Feature:
- Macro: ADDSUB_SEQ_SAT_EN.
- Defined: on the DONE-entry edge, if overflow=1, result is replaced by the signed saturation value:
  - 0x7F..FF when A_msb=0;
  - 0x80..00 when A_msb=1.
  - overflow still reports 1. carry_out is unchanged. Latency is unchanged.
- Undefined: result is the wrapped value. No saturation logic is synthesised.

Test Plan:
- Reset/idle: rst_n low 3 cycles then high -> in_ready=1, out_valid=0, busy=0, result=0x00000000.
- Carry ripple (NBYTES=4): A=0x00FFFFFF, B=0x00000001, op_sub=0 -> out_valid exactly 4 edges after accept; result=0x01000000, carry_out=0, overflow=0.
- Borrow (NBYTES=4): A=0x00000000, B=0x00000001, op_sub=1 -> result=0xFFFFFFFF, carry_out=0, overflow=0. Then A=5, B=3, op_sub=1 -> result=0x00000002, carry_out=1.
- Overflow: A=0x7FFFFFFF, B=0x00000001, op_sub=0 -> overflow=1. Without the macro result=0x80000000; with ADDSUB_SEQ_SAT_EN result=0x7FFFFFFF. Also A=0x80000000, B=1, op_sub=1 -> overflow=1; saturated result=0x80000000, wrapped result=0x7FFFFFFF.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid, and toggle op_a/in_valid meanwhile -> result, flags and in_ready=0 stay stable. out_ready=1 -> IDLE next edge; the next transaction is accepted only on a later edge.
- Reset mid-op: accept A=0x12345678, B=0x11111111, assert rst_n low after 2 RUN edges -> immediate return to reset values, no out_valid. A fresh transaction after reset returns 0x23456789.

Source files
------------

// File: rtl/addsub_seq.sv
// Byte-serial multi-word adder/subtractor: one 8-bit slice per cycle, LSB first.
// Optional signed saturation of the final result when ADDSUB_SEQ_SAT_EN is defined.
module addsub_seq #(
  parameter int NBYTES = 4,
  parameter int IDXW   = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  busy
);

  localparam int W = 8 * NBYTES;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            c_q, c_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      a_byte, b_byte;
  logic [8:0]      s;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    a_byte   = '0;
    b_byte   = '0;
    s        = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          // Subtraction as A + ~B + 1: invert B here, the +1 enters as the initial carry.
          b_d     = op_b ^ {W{op_sub}};
          c_d     = op_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDXW'(i)) begin
            a_byte = a_q[8*i +: 8];
            b_byte = b_q[8*i +: 8];
          end
        end
        s = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, c_q};
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDXW'(i)) begin
            result_d[8*i +: 8] = s[7:0];
          end
        end
        c_d = s[8];
        if (idx_q == IDXW'(NBYTES - 1)) begin
          carry_d = s[8];
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (s[7] != a_q[W-1]);
`ifdef ADDSUB_SEQ_SAT_EN
          if ((a_q[W-1] == b_q[W-1]) && (s[7] != a_q[W-1])) begin
            result_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
`endif
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule
